serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one operand bit per clock, LSB first, with a
// registered carry between bits. A start/busy/done handshake launches an add
// and hands back sum and carry_out, which are held until the next result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       fa;
  logic             fa_sum;
  logic             fa_carry;

  // Full adder built from two half adders plus an OR; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic s1;
    logic c1;
    logic c2;
    s1 = x ^ y;
    c1 = x & y;
    c2 = s1 & ci;
    return {c1 | c2, s1 ^ ci};
  endfunction

  assign fa       = full_add(a_sh[0], b_sh[0], c);
  assign fa_sum   = fa[0];
  assign fa_carry = fa[1];

  // Handshake FSM and serial datapath; busy/done are registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      c         <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          c      <= fa_carry;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Final bit: publish the completed word and carry together.
            sum       <= {fa_sum, res_sh[WIDTH-1:1]};
            carry_out <= fa_carry;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  sum8;
  logic        carry_out8;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [15:0] sum16;
  logic        carry_out16;

  int checks;
  int errors;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .sum       (sum8),
    .carry_out (carry_out8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start16),
    .a         (a16),
    .b         (b16),
    .busy      (busy16),
    .done      (done16),
    .sum       (sum16),
    .carry_out (carry_out16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Launch one add on the selected instance, wait (bounded) for it to finish.
  task automatic run_op(input bit wide, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] s, output logic co,
                        output int lat, output int bcnt);
    logic bz;
    logic dn;
    if (wide) begin start16 = 1'b1; a16 = av[15:0]; b16 = bv[15:0]; end
    else      begin start8  = 1'b1; a8  = av[7:0];  b8  = bv[7:0];  end
    @(posedge clk); #1;
    start8 = 1'b0;
    start16 = 1'b0;
    lat = -1;
    bcnt = 0;
    s = '0;
    co = 1'b0;
    bz = wide ? busy16 : busy8;
    if (bz) bcnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      bz = wide ? busy16 : busy8;
      dn = wide ? done16 : done8;
      if (bz) bcnt++;
      if (dn) begin
        lat = k;
        s   = wide ? 32'(sum16) : 32'(sum8);
        co  = wide ? carry_out16 : carry_out8;
      end
      if (!bz) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", sum8); end
    checks++; if (carry_out8 !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", carry_out8); end
    checks++; if (sum16 !== 16'h0000 || busy16 !== 1'b0) begin
      errors++; $display("FAIL reset_w16 got sum %h busy %b exp 0000 0", sum16, busy16);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [31:0] s; logic co; int lat; int bcnt;
    run_op(1'b0, 32'h5A, 32'h3C, s, co, lat, bcnt);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d exp 8 edges after start edge", lat); end
    checks++; if (bcnt !== 9) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 9", bcnt); end
    checks++; if (s !== 32'h96) begin errors++; $display("FAIL basic_sum got %h exp 96", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_carry got %b exp 0", co); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done8); end
    checks++; if (sum8 !== 8'h96) begin errors++; $display("FAIL basic_sum_held got %h exp 96", sum8); end
  endtask

  task automatic test_boundaries;
    logic [31:0] s; logic co; int lat; int bcnt;
    run_op(1'b0, 32'hFF, 32'h01, s, co, lat, bcnt);
    checks++; if (s !== 32'h00 || co !== 1'b1) begin errors++; $display("FAIL ff_plus_01 got %b_%h exp 1_00", co, s); end
    run_op(1'b0, 32'hFF, 32'hFF, s, co, lat, bcnt);
    checks++; if (s !== 32'hFE || co !== 1'b1) begin errors++; $display("FAIL ff_plus_ff got %b_%h exp 1_fe", co, s); end
    run_op(1'b0, 32'h00, 32'h00, s, co, lat, bcnt);
    checks++; if (s !== 32'h00 || co !== 1'b0) begin errors++; $display("FAIL zero_plus_zero got %b_%h exp 0_00", co, s); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL zero_latency got %0d exp 8", lat); end
  endtask

  task automatic test_back_to_back;
    int ndone;
    int se;
    logic prev;
    logic [8:0] exp;
    ndone = 0;
    prev = 1'b0;
    for (int k = 0; k < 30; k++) begin
      start8 = 1'b1;
      a8 = 8'(k * 37 + 5);
      b8 = 8'(k * 11 + 3);
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        se = k - 8;
        exp = 9'(8'(se * 37 + 5)) + 9'(8'(se * 11 + 3));
        checks++; if (se % 10 != 0) begin errors++; $display("FAIL b2b_spacing done at edge %0d exp start edge multiple of 10", k); end
        checks++; if ({carry_out8, sum8} !== exp) begin errors++; $display("FAIL b2b_result got %h exp %h", {carry_out8, sum8}, exp); end
        checks++; if (prev) begin errors++; $display("FAIL b2b_double_done got 2 consecutive exp 1"); end
      end
      prev = done8;
    end
    start8 = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", ndone); end
  endtask

  task automatic test_ignored_start;
    logic [31:0] s; logic co; int lat; int bcnt;
    int seen;
    seen = -1;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      start8 = (k == 3 || k == 5 || k == 9);
      a8 = 8'h11; b8 = 8'h22;
      @(posedge clk); #1;
      if (done8) seen = k;
    end
    start8 = 1'b0;
    checks++; if (seen !== 8) begin errors++; $display("FAIL ign_done_edge got %0d exp 8", seen); end
    checks++; if (sum8 !== 8'h46 || carry_out8 !== 1'b0) begin errors++; $display("FAIL ign_result got %b_%h exp 0_46", carry_out8, sum8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ign_no_queue busy got %b exp 0", busy8); end
    run_op(1'b0, 32'h11, 32'h22, s, co, lat, bcnt);
    checks++; if (s !== 32'h33 || co !== 1'b0) begin errors++; $display("FAIL ign_followup got %b_%h exp 0_33", co, s); end
  endtask

  task automatic test_async_reset;
    logic [31:0] s; logic co; int lat; int bcnt;
    logic seen;
    run_op(1'b0, 32'hFF, 32'hFF, s, co, lat, bcnt);
    checks++; if (s !== 32'hFE || co !== 1'b1) begin errors++; $display("FAIL rst_pre got %b_%h exp 1_fe", co, s); end
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done8); end
    checks++; if (sum8 !== 8'h00 || carry_out8 !== 1'b0) begin errors++; $display("FAIL rst_mid_result got %b_%h exp 0_00", carry_out8, sum8); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_abandon got activity exp none"); end
    run_op(1'b0, 32'h80, 32'h80, s, co, lat, bcnt);
    checks++; if (s !== 32'h00 || co !== 1'b1) begin errors++; $display("FAIL rst_after got %b_%h exp 1_00", co, s); end
  endtask

  task automatic test_random(input bit wide, input int n);
    logic [31:0] av; logic [31:0] bv; logic [32:0] full;
    logic [31:0] s; logic co; int lat; int bcnt;
    logic [31:0] es; logic ec; int w;
    w = wide ? 16 : 8;
    for (int i = 0; i < n; i++) begin
      av = $urandom;
      bv = $urandom;
      if (wide) begin av = av & 32'hFFFF; bv = bv & 32'hFFFF; end
      else      begin av = av & 32'hFF;   bv = bv & 32'hFF;   end
      full = {1'b0, av} + {1'b0, bv};
      es = wide ? (full[31:0] & 32'hFFFF) : (full[31:0] & 32'hFF);
      ec = wide ? full[16] : full[8];
      run_op(wide, av, bv, s, co, lat, bcnt);
      checks++; if (s !== es || co !== ec) begin errors++; $display("FAIL rand_w%0d %h+%h got %b_%h exp %b_%h", w, av, bv, co, s, ec, es); end
      checks++; if (bcnt !== w + 1) begin errors++; $display("FAIL rand_w%0d_busy got %0d exp %0d", w, bcnt, w + 1); end
      checks++; if (lat !== w) begin errors++; $display("FAIL rand_w%0d_latency got %0d exp %0d", w, lat, w); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_ignored_start();
    test_async_reset();
    test_random(1'b0, 1000);
    test_random(1'b1, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
